// File: rtl/mem_access_unit.sv
// mem_access_unit
// Memory-side stage behind the multicycle controller. It turns a load or
// store request into word-wide memory transactions and waits for mem_ack
// before it drops a strobe. Byte and halfword loads are sign- or
// zero-extended. Byte and halfword stores are done as read-modify-write.
// Byte order is big-endian: byte 0 is bits 31:24.
//
// Ports
//   clk, rst_n        clock; synchronous active-low reset
//   req_read/write    request pulses, sampled only while idle
//   size, sign_ext    access size (00 B, 01 H, 10 W, 11 illegal), load extension
//   addr, wdata       byte address and store data (sub-word data in low bits)
//   rdata             extended load result, held until the next load completes
//   busy, done        not idle / one-cycle completion pulse
//   align_err         pulses with done on a misaligned or illegal access
//   mem_*             word-aligned memory port with an ack handshake
//
// State | meaning
//   IDLE   | waiting for a request
//   RD     | load read strobe, waiting for mem_ack
//   WR     | word store write strobe, waiting for mem_ack
//   RMW_RD | sub-word store, reading the old word
//   RMW_WR | sub-word store, writing the merged word
//   FIN    | raise done (and align_err if flagged), then return to IDLE
module mem_access_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              done,
    output logic              align_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        RMW_RD,
        RMW_WR,
        FIN
    } state_t;

    state_t      state;
    logic [1:0]  lane_q;
    logic [1:0]  size_q;
    logic        sign_q;
    logic        err_q;
    logic [15:0] wdata_q;   // a sub-word store never needs more than 16 bits

    logic              misaligned;
    logic [7:0]        sel_byte;
    logic [15:0]       sel_half;
    logic [DATA_W-1:0] load_ext;
    logic [DATA_W-1:0] merged;

    always_comb begin
        misaligned = 1'b0;
        case (size)
            2'b01:   misaligned = addr[0];
            2'b10:   misaligned = (addr[1:0] != 2'b00);
            2'b11:   misaligned = 1'b1;
            default: misaligned = 1'b0;
        endcase
    end

    // Lane selection and extension of the word being returned by memory.
    always_comb begin
        sel_byte = mem_rdata[31:24];
        case (lane_q)
            2'd0:    sel_byte = mem_rdata[31:24];
            2'd1:    sel_byte = mem_rdata[23:16];
            2'd2:    sel_byte = mem_rdata[15:8];
            default: sel_byte = mem_rdata[7:0];
        endcase
        sel_half = lane_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];

        load_ext = mem_rdata;
        case (size_q)
            2'b00:   load_ext = sign_q ? {{24{sel_byte[7]}}, sel_byte} : {24'h0, sel_byte};
            2'b01:   load_ext = sign_q ? {{16{sel_half[15]}}, sel_half} : {16'h0, sel_half};
            default: load_ext = mem_rdata;
        endcase
    end

    // New store data merged into the old word, built in the same cycle the
    // read is acknowledged so the write can start on the next edge.
    always_comb begin
        merged = mem_rdata;
        if (size_q == 2'b00) begin
            case (lane_q)
                2'd0:    merged[31:24] = wdata_q[7:0];
                2'd1:    merged[23:16] = wdata_q[7:0];
                2'd2:    merged[15:8]  = wdata_q[7:0];
                default: merged[7:0]   = wdata_q[7:0];
            endcase
        end else if (lane_q[1]) begin
            merged[15:0] = wdata_q;
        end else begin
            merged[31:16] = wdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            lane_q    <= 2'b00;
            size_q    <= 2'b00;
            sign_q    <= 1'b0;
            err_q     <= 1'b0;
            wdata_q   <= 16'h0;
            rdata     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            align_err <= 1'b0;
            mem_addr  <= '0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else begin
            done      <= 1'b0;
            align_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_read || req_write) begin
                        lane_q  <= addr[1:0];
                        size_q  <= size;
                        sign_q  <= sign_ext;
                        wdata_q <= wdata[15:0];
                        busy    <= 1'b1;
                        if (misaligned) begin
                            err_q <= 1'b1;
                            state <= FIN;
                        end else begin
                            err_q    <= 1'b0;
                            mem_addr <= {addr[ADDR_W-1:2], 2'b00};
                            // A simultaneous read and write is treated as a write.
                            if (!req_write) begin
                                state  <= RD;
                                mem_re <= 1'b1;
                            end else if (size == 2'b10) begin
                                state     <= WR;
                                mem_we    <= 1'b1;
                                mem_wdata <= wdata;
                            end else begin
                                state  <= RMW_RD;
                                mem_re <= 1'b1;
                            end
                        end
                    end
                end
                RD: begin
                    if (mem_ack) begin
                        mem_re <= 1'b0;
                        rdata  <= load_ext;
                        state  <= FIN;
                    end
                end
                RMW_RD: begin
                    if (mem_ack) begin
                        mem_re    <= 1'b0;
                        mem_we    <= 1'b1;
                        mem_wdata <= merged;
                        state     <= RMW_WR;
                    end
                end
                WR, RMW_WR: begin
                    if (mem_ack) begin
                        mem_we <= 1'b0;
                        state  <= FIN;
                    end
                end
                FIN: begin
                    done      <= 1'b1;
                    align_err <= err_q;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    mem_re <= 1'b0;
                    mem_we <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_read, req_write;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        busy, done, align_err;
    logic [31:0] mem_addr;
    logic        mem_re, mem_we;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_ack;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_read(req_read), .req_write(req_write),
        .size(size), .sign_ext(sign_ext), .addr(addr), .wdata(wdata),
        .rdata(rdata), .busy(busy), .done(done), .align_err(align_err),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Memory model: 64 words, ack after wait_cycles strobe cycles.
    logic [31:0] mem [0:63];
    int wait_cycles = 0;
    int strobe_cnt = 0;
    int cyc = 0;

    assign mem_ack   = (mem_re || mem_we) && (strobe_cnt == wait_cycles);
    assign mem_rdata = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if ((mem_re || mem_we) && !mem_ack) strobe_cnt <= strobe_cnt + 1;
        else                                strobe_cnt <= 0;
        if (mem_we && mem_ack) mem[mem_addr[7:2]] <= mem_wdata;
    end

    // Scoreboard
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          start;
        int          nre;
        int          nwe;
        int          re_base;
        int          we_base;
    } exp_t;

    typedef struct {
        logic [31:0] waddr;
        logic [31:0] wword;
    } wr_t;

    exp_t exp_q[$];
    wr_t  wr_q[$];
    int   done_count = 0;
    int   re_cnt = 0;
    int   we_cnt = 0;
    logic        prev_strobe = 1'b0, prev_ack = 1'b0, prev_re = 1'b0, prev_we = 1'b0;
    logic [31:0] prev_addr = '0, prev_wdata = '0;

    always @(negedge clk) begin
        exp_t e;
        wr_t  w;
        if (mem_re) re_cnt++;
        if (mem_we) we_cnt++;
        if (mem_re && mem_we) chk("one_strobe", {mem_re, mem_we}, 32'h1);
        if ((mem_re || mem_we) && prev_strobe && !prev_ack) begin
            chk("stable_addr",  mem_addr,  prev_addr);
            chk("stable_wdata", mem_wdata, prev_wdata);
            chk("stable_strb",  {mem_re, mem_we}, {prev_re, prev_we});
        end
        if (align_err && !done) chk("align_err_alone", align_err, 1'b0);
        if (mem_we && mem_ack) begin
            if (wr_q.size() == 0) begin
                chk("unexpected_write", mem_addr, 32'hFFFFFFFF);
            end else begin
                w = wr_q.pop_front();
                chk("write_addr", mem_addr,  w.waddr);
                chk("write_data", mem_wdata, w.wword);
            end
        end
        if (done) begin
            done_count++;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", done, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk("rdata",     rdata, e.rdata);
                chk("align_err", 32'(align_err), 32'(e.err));
                chk("latency",   32'(cyc - e.start), 32'(e.lat));
                chk("re_cycles", 32'(re_cnt - e.re_base), 32'(e.nre));
                chk("we_cycles", 32'(we_cnt - e.we_base), 32'(e.nwe));
            end
        end
        prev_strobe = mem_re || mem_we;
        prev_re     = mem_re;
        prev_we     = mem_we;
        prev_ack    = mem_ack;
        prev_addr   = mem_addr;
        prev_wdata  = mem_wdata;
    end

    logic [31:0] model_rdata = 32'h0;

    task automatic do_req(input logic rd, input logic wr, input logic [1:0] sz,
                          input logic sx, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic err, input int lat,
                          input int nre, input int nwe, input logic has_wr,
                          input logic [31:0] wr_word, input logic poke);
        exp_t e;
        wr_t  w;
        int   d0;
        int   t;
        @(posedge clk); #1;
        req_read = rd; req_write = wr; size = sz; sign_ext = sx; addr = a; wdata = wd;
        if (has_wr) begin
            w.waddr = {a[31:2], 2'b00};
            w.wword = wr_word;
            wr_q.push_back(w);
        end
        d0 = done_count;
        @(posedge clk); #1;
        req_read = 1'b0; req_write = 1'b0;
        addr = 32'h0000_00FF; wdata = 32'hDEAD_BEEF; size = 2'b10; sign_ext = 1'b1;
        if (rd && !wr && !err) model_rdata = exp_rd;
        e.rdata = model_rdata; e.err = err; e.lat = lat; e.start = cyc;
        e.nre = nre; e.nwe = nwe; e.re_base = re_cnt; e.we_base = we_cnt;
        exp_q.push_back(e);
        if (poke) begin
            @(posedge clk); #1;
            req_read = 1'b1; req_write = 1'b1; addr = 32'h48; size = 2'b10;
            @(posedge clk); #1;
            req_read = 1'b0; req_write = 1'b0;
        end
        t = 0;
        while (done_count == d0 && t < 60) begin
            @(posedge clk); #1;
            t++;
        end
        chk("done_timeout", 32'(done_count != d0), 32'h1);
        repeat (4) @(posedge clk);
        #1;
        chk("single_done", 32'(done_count - d0), 32'h1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int w0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        rst_n = 1'b0; req_read = 1'b0; req_write = 1'b0; size = 2'b00;
        sign_ext = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {rdata[0], busy, done, align_err, mem_re, mem_we},  32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        rst_n = 1'b1;

        // Loads: word zero-wait, then sub-word with three wait cycles.
        mem[16] = 32'h8899AABB;
        wait_cycles = 0;
        do_req(1, 0, 2'b10, 0, 32'h40, 0, 32'h8899AABB, 0, 2, 1, 0, 0, 0, 0);
        wait_cycles = 3;
        do_req(1, 0, 2'b00, 1, 32'h41, 0, 32'hFFFFFF99, 0, 5, 4, 0, 0, 0, 0);
        do_req(1, 0, 2'b00, 0, 32'h41, 0, 32'h00000099, 0, 5, 4, 0, 0, 0, 0);
        do_req(1, 0, 2'b01, 1, 32'h42, 0, 32'hFFFFAABB, 0, 5, 4, 0, 0, 0, 0);
        wait_cycles = 1;
        do_req(1, 0, 2'b01, 0, 32'h40, 0, 32'h00008899, 0, 3, 2, 0, 0, 0, 0);
        do_req(1, 0, 2'b00, 1, 32'h43, 0, 32'hFFFFFFBB, 0, 3, 2, 0, 0, 0, 0);

        // Sub-word stores via read-modify-write.
        mem[16] = 32'h11223344;
        wait_cycles = 0;
        do_req(0, 1, 2'b00, 0, 32'h42, 32'h000000EE, 0, 0, 3, 1, 1, 1, 32'h1122EE44, 0);
        do_req(1, 0, 2'b10, 0, 32'h40, 0, 32'h1122EE44, 0, 2, 1, 0, 0, 0, 0);
        wait_cycles = 2;
        do_req(0, 1, 2'b01, 0, 32'h40, 32'h1234ABCD, 0, 0, 7, 3, 3, 1, 32'hABCDEE44, 0);
        wait_cycles = 0;
        do_req(0, 1, 2'b00, 0, 32'h43, 32'hFFFFFF5A, 0, 0, 3, 1, 1, 1, 32'hABCDEE5A, 0);

        // Misaligned / illegal: no strobe, done+align_err after one cycle, rdata held.
        do_req(0, 1, 2'b01, 0, 32'h43, 32'h0000FFFF, 0, 1, 1, 0, 0, 0, 0, 0);
        do_req(1, 0, 2'b10, 0, 32'h42, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        do_req(1, 0, 2'b11, 0, 32'h44, 0, 0, 1, 1, 0, 0, 0, 0, 0);

        // Both requests high: treated as a word write; then read it back
        // with a request poked while busy.
        do_req(1, 1, 2'b10, 0, 32'h44, 32'hCAFEBABE, 0, 0, 2, 0, 1, 1, 32'hCAFEBABE, 0);
        wait_cycles = 3;
        do_req(1, 0, 2'b10, 0, 32'h44, 0, 32'hCAFEBABE, 0, 5, 4, 0, 0, 0, 1);
        chk("mem_word16", mem[16], 32'hABCDEE5A);

        // Reset during RMW_RD aborts the access.
        wait_cycles = 5;
        @(posedge clk); #1;
        req_write = 1'b1; size = 2'b00; addr = 32'h40; wdata = 32'h77;
        @(posedge clk); #1;
        req_write = 1'b0;
        chk("rmw_rd_re", 32'(mem_re), 32'h1);
        d0 = done_count;
        w0 = we_cnt;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_strobes", {mem_re, mem_we, busy, done, align_err}, 32'h0);
        chk("abort_rdata", rdata, 32'h0);
        chk("abort_mem_addr", mem_addr, 32'h0);
        chk("abort_mem_wdata", mem_wdata, 32'h0);
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(done_count - d0), 32'h0);
        chk("abort_no_write", 32'(we_cnt - w0), 32'h0);
        chk("abort_mem_kept", mem[16], 32'hABCDEE5A);
        chk("pending_expects", 32'(exp_q.size() + wr_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
